// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and fault cause encodings.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_RANGE    = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } fault_cause_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store-side enables/replication and
// alignment check, load-side lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  output logic        st_misaligned_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    st_be_o         = 4'b0000;
    st_wdata_o      = 32'h0;
    st_misaligned_o = 1'b0;
    case (st_funct3_i)
      F3_B, F3_BU: begin
        st_be_o    = 4'b0001 << st_addr_lo_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      F3_H, F3_HU: begin
        st_be_o         = 4'b0011 << st_addr_lo_i;
        st_wdata_o      = {2{st_wdata_i[15:0]}};
        st_misaligned_o = st_addr_lo_i[0];
      end
      F3_W: begin
        st_be_o         = 4'b1111;
        st_wdata_o      = st_wdata_i;
        st_misaligned_o = (st_addr_lo_i != 2'b00);
      end
      default: st_misaligned_o = 1'b1;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign ld_shifted = ld_rdata_i >> {ld_addr_lo_i, 3'b000};

  always_comb begin
    ld_data_o = 32'h0;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_BU:   ld_data_o = {24'h0, ld_shifted[7:0]};
      F3_H:    ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_HU:   ld_data_o = {16'h0, ld_shifted[15:0]};
      F3_W:    ld_data_o = ld_rdata_i;
      default: ld_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one outstanding word-addressed memory request
// with byte enables, alignment/range checks and a bus timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  output logic        stall
);

  lsu_state_e   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [2:0]   funct3_q, funct3_d;
  logic [1:0]   addr_lo_q, addr_lo_d;
  logic [4:0]   rd_q, rd_d;

  logic         mem_req_q, mem_req_d;
  logic         mem_we_q, mem_we_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [3:0]   mem_be_q, mem_be_d;
  logic [31:0]  mem_wdata_q, mem_wdata_d;

  logic         resp_valid_q, resp_valid_d;
  logic [31:0]  resp_rdata_q, resp_rdata_d;
  logic [4:0]   resp_rd_q, resp_rd_d;
  logic         fault_q, fault_d;
  fault_cause_e fault_cause_q, fault_cause_d;
  logic [31:0]  fault_addr_q, fault_addr_d;

  logic         accept;
  logic         misaligned;
  logic         out_of_range;
  logic         timeout_hit;
  logic [3:0]   st_be;
  logic [31:0]  st_wdata;
  logic [31:0]  ld_data;

  lsu_align u_align (
    .st_funct3_i     (req_funct3),
    .st_addr_lo_i    (req_addr[1:0]),
    .st_wdata_i      (req_wdata),
    .st_be_o         (st_be),
    .st_wdata_o      (st_wdata),
    .st_misaligned_o (misaligned),
    .ld_funct3_i     (funct3_q),
    .ld_addr_lo_i    (addr_lo_q),
    .ld_rdata_i      (mem_rdata),
    .ld_data_o       (ld_data)
  );

  assign accept       = req_valid && (state_q == IDLE);
  assign out_of_range = ({2'b00, req_addr[31:2]} >= DEPTH_WORDS);
  // The last waiting cycle is the one where the counter would reach TIMEOUT.
  assign timeout_hit  = (cnt_q == 4'(TIMEOUT - 1));

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !misaligned && !out_of_range) state_d = WAIT;
      WAIT: begin
        if (mem_ack)          state_d = RESP;
        else if (timeout_hit) state_d = IDLE;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cnt_d         = 4'd0;
    funct3_d      = funct3_q;
    addr_lo_d     = addr_lo_q;
    rd_d          = rd_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = 32'h0;
    resp_rd_d     = 5'd0;
    fault_d       = 1'b0;
    fault_cause_d = CAUSE_NONE;
    fault_addr_d  = 32'h0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned || out_of_range) begin
            fault_d       = 1'b1;
            fault_cause_d = misaligned ? CAUSE_MISALIGN : CAUSE_RANGE;
            fault_addr_d  = req_addr;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {2'b00, req_addr[31:2]};
            mem_be_d    = st_be;
            mem_wdata_d = st_wdata;
            funct3_d    = req_funct3;
            addr_lo_d   = req_addr[1:0];
            rd_d        = req_rd;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (mem_ack || timeout_hit) begin
          cnt_d       = 4'd0;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'h0;
          mem_be_d    = 4'b0000;
          mem_wdata_d = 32'h0;
        end
        if (mem_ack) begin
          resp_valid_d = 1'b1;
          if (!mem_we_q) begin
            resp_rdata_d = ld_data;
            resp_rd_d    = rd_q;
          end
        end else if (timeout_hit) begin
          fault_d       = 1'b1;
          fault_cause_d = CAUSE_TIMEOUT;
          fault_addr_d  = {mem_addr_q[29:0], addr_lo_q};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= 4'd0;
      funct3_q      <= 3'd0;
      addr_lo_q     <= 2'd0;
      rd_q          <= 5'd0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_be_q      <= 4'b0000;
      mem_wdata_q   <= 32'h0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'h0;
      resp_rd_q     <= 5'd0;
      fault_q       <= 1'b0;
      fault_cause_q <= CAUSE_NONE;
      fault_addr_q  <= 32'h0;
    end else begin
      cnt_q         <= cnt_d;
      funct3_q      <= funct3_d;
      addr_lo_q     <= addr_lo_d;
      rd_q          <= rd_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_rd_q     <= resp_rd_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign stall       = (state_q != IDLE);
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_rd     = resp_rd_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;
  assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases, randomized traffic,
// a memory responder and a response monitor checking against a byte-level model.
module tb_load_store_unit;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  logic        stall;

  typedef struct packed {
    logic        is_fault;
    logic [1:0]  cause;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [4:0]  rd;
  } exp_resp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  delay;
    logic        no_ack;
  } mem_exp_t;

  exp_resp_t resp_q[$];
  mem_exp_t  mem_q[$];
  int        n_tests = 0;
  int        n_fail  = 0;
  logic      force_ack = 1'b0;

  load_store_unit #(.DEPTH_WORDS(1024), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .fault(fault), .fault_cause(fault_cause), .fault_addr(fault_addr), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works on byte sizes and offsets, not on the RTL's tables.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic [4:0] rd, output logic faulty,
                                output exp_resp_t r, output mem_exp_t m);
    int size;
    int off;
    logic [31:0] val;
    logic [31:0] mask;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 0;
    endcase
    off = int'(addr % 4);
    r = '0;
    m = '0;
    faulty = 1'b1;
    r.is_fault = 1'b1;
    r.addr = addr;
    if (size == 0 || (off % size) != 0) begin
      r.cause = 2'b01;
    end else if ((addr / 4) >= 1024) begin
      r.cause = 2'b10;
    end else begin
      faulty = 1'b0;
      r = '0;
      m.we = we;
      m.addr = addr / 4;
      for (int i = 0; i < 4; i++) begin
        m.be[i] = (i >= off) && (i < off + size);
        m.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
      end
      if (!we) begin
        val = rdata >> (8 * off);
        if (size < 4) begin
          mask = (32'h1 << (8 * size)) - 32'h1;
          val = val & mask;
          if (f3[2] == 1'b0 && val[8*size-1]) val = val | ~mask;
        end
        r.rdata = val;
        r.rd = rd;
      end
    end
  endfunction

  // Memory responder: checks each request against the model and acks after
  // the chosen delay (or never).
  mem_exp_t cur;
  logic     in_req = 1'b0;
  int       wait_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_req = 1'b0;
      mem_ack = 1'b0;
      wait_cnt = 0;
    end else if (mem_req) begin
      if (!in_req) begin
        in_req = 1'b1;
        wait_cnt = 0;
        if (mem_q.size() == 0) begin
          check("unexpected_mem_req", 32'(mem_req), 32'd0);
          cur = '0;
          cur.no_ack = 1'b1;
        end else begin
          cur = mem_q.pop_front();
        end
      end
      check("mem_we", 32'(mem_we), 32'(cur.we));
      check("mem_addr", mem_addr, cur.addr);
      check("mem_be", 32'(mem_be), 32'(cur.be));
      if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
      if (!cur.no_ack && wait_cnt == int'(cur.delay)) begin
        mem_ack = 1'b1;
        mem_rdata = cur.rdata;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        wait_cnt++;
      end
    end else begin
      in_req = 1'b0;
      mem_ack = force_ack;
      mem_rdata = $urandom;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (rst_n && (resp_valid || fault)) begin
      if (resp_q.size() == 0) begin
        check("unexpected_output", {30'h0, resp_valid, fault}, 32'd0);
      end else begin
        exp_resp_t e;
        e = resp_q.pop_front();
        if (e.is_fault) begin
          check("fault_pulse", {30'h0, resp_valid, fault}, 32'd1);
          check("fault_cause", 32'(fault_cause), 32'(e.cause));
          check("fault_addr", fault_addr, e.addr);
        end else begin
          check("resp_pulse", {30'h0, resp_valid, fault}, 32'd2);
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_rd", 32'(resp_rd), 32'(e.rd));
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                       input logic [3:0] delay, input logic no_ack);
    logic faulty;
    exp_resp_t r;
    mem_exp_t m;
    int budget = 0;
    while (!req_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    model(we, f3, addr, wdata, rdata, rd, faulty, r, m);
    if (!faulty && no_ack) begin
      r = '0;
      r.is_fault = 1'b1;
      r.cause = 2'b11;
      r.addr = addr;
    end
    resp_q.push_back(r);
    if (!faulty) begin
      m.rdata = rdata;
      m.delay = delay;
      m.no_ack = no_ack;
      mem_q.push_back(m);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
  endtask

  // Zero-latency access with cycle-exact checks against literal values.
  task automatic run_directed(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd,
                              input logic [31:0] rdata, input logic [31:0] x_maddr,
                              input logic [3:0] x_be, input logic [31:0] x_wdata,
                              input logic [31:0] x_rdata);
    issue(we, f3, addr, wdata, rd, rdata, 4'd0, 1'b0);
    @(negedge clk);
    check("d_stall_t1", 32'(stall), 32'd1);
    check("d_mem_req_t1", 32'(mem_req), 32'd1);
    check("d_mem_addr", mem_addr, x_maddr);
    check("d_mem_be", 32'(mem_be), 32'(x_be));
    if (we) check("d_mem_wdata", mem_wdata, x_wdata);
    @(negedge clk);
    check("d_resp_valid_t2", 32'(resp_valid), 32'd1);
    check("d_resp_rdata", resp_rdata, x_rdata);
    check("d_ready_in_resp", 32'(req_ready), 32'd0);
    check("d_mem_req_t2", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("d_stall_t3", 32'(stall), 32'd0);
  endtask

  logic [2:0] valid_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    int cnt;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_cause", 32'(fault_cause), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_directed(1'b1, 3'b010, 32'h1C, 32'hDEADBEEF, 5'd3, 32'h0, 32'd7, 4'b1111, 32'hDEADBEEF, 32'h0);
    run_directed(1'b0, 3'b000, 32'h1D, 32'h0, 5'd5, 32'h12348056, 32'd7, 4'b0010, 32'h0, 32'hFFFFFF80);
    run_directed(1'b0, 3'b100, 32'h1D, 32'h0, 5'd5, 32'h12348056, 32'd7, 4'b0010, 32'h0, 32'h00000080);
    run_directed(1'b1, 3'b001, 32'h06, 32'h0000ABCD, 5'd9, 32'h0, 32'd1, 4'b1100, 32'hABCDABCD, 32'h0);
    run_directed(1'b0, 3'b101, 32'h06, 32'h0, 5'd10, 32'hABCD0000, 32'd1, 4'b1100, 32'h0, 32'h0000ABCD);

    issue(1'b0, 3'b010, 32'h2, 32'h0, 5'd1, 32'h0, 4'd0, 1'b0);
    @(negedge clk);
    check("misalign_fault", 32'(fault), 32'd1);
    check("misalign_cause", 32'(fault_cause), 32'd1);
    check("misalign_no_req", 32'(mem_req), 32'd0);
    issue(1'b0, 3'b010, 32'h1000, 32'h0, 5'd1, 32'h0, 4'd0, 1'b0);
    @(negedge clk);
    check("range_cause", 32'(fault_cause), 32'd2);
    check("range_no_req", 32'(mem_req), 32'd0);

    issue(1'b0, 3'b010, 32'h80, 32'h0, 5'd4, 32'h0, 4'd0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req) cnt++;
      else break;
    end
    check("timeout_req_cycles", 32'(cnt), 32'd15);
    check("timeout_cause", 32'(fault_cause), 32'd3);
    check("timeout_ready", 32'(req_ready), 32'd1);
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_ack_no_req", 32'(mem_req), 32'd0);
      check("late_ack_no_resp", 32'(resp_valid), 32'd0);
    end
    force_ack = 1'b0;

    issue(1'b0, 3'b010, 32'h44, 32'h0, 5'd6, 32'h0, 4'd0, 1'b1);
    repeat (3) @(negedge clk);
    check("pre_reset_req", 32'(mem_req), 32'd1);
    resp_q.delete();
    mem_q.delete();
    rst_n = 1'b0;
    #1;
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_no_out", {30'h0, resp_valid, fault}, 32'd0);
    end
    rst_n = 1'b1;
    run_directed(1'b1, 3'b000, 32'h3, 32'h000000A5, 5'd2, 32'h0, 32'd0, 4'b1000, 32'hA5A5A5A5, 32'h0);

    for (int n = 0; n < 200; n++) begin
      logic [2:0]  f3;
      logic [31:0] word;
      logic [1:0]  off;
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else                           f3 = valid_f3[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) word = $urandom_range(1024, 32'h3FFF_FFFF);
      else                           word = $urandom_range(0, 1023);
      off = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) off = 2'b00;
      issue(1'($urandom_range(0, 1)), f3, {word[29:0], off}, $urandom,
            5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 3)), 1'b0);
    end

    for (int i = 0; i < 100; i++) begin
      if (resp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_resp_q", 32'(resp_q.size()), 32'd0);
    check("drain_mem_q", 32'(mem_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage load/store unit placed directly upstream of the data memory.
- Accepts one memory operation at a time from the EX/MEM pipeline register and aligns store data into byte lanes.
- Drives a word-addressed memory request with byte enables over a req/ack handshake, then extracts and sign/zero-extends load data.
- Detects misaligned and out-of-range accesses, and stalls the pipeline while a request is outstanding.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in data memory; word index >= DEPTH_WORDS is an access fault.
- TIMEOUT, 15, maximum cycles in WAIT without mem_ack before a bus fault is raised (4-bit counter).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  EX/MEM holds a load or store
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_rd  in  5  load destination register
- mem_req  out  1  memory request valid
- mem_we  out  1  memory write
- mem_addr  out  32  word index (byte address >> 2)
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_wdata  out  32  lane-aligned store data
- mem_ack  in  1  memory completed the request this cycle
- mem_rdata  in  32  read word, valid with mem_ack
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores)
- resp_rd  out  5  destination register (0 for stores)
- fault  out  1  one-cycle exception pulse
- fault_cause  out  2  01 misaligned, 10 out of range, 11 timeout
- fault_addr  out  32  offending byte address
- stall  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state IDLE; all mem_*, resp_*, fault, fault_cause, fault_addr and the counter at 0; req_ready = 1.
- req_ready = (state == IDLE). A request is accepted when req_valid & req_ready.
- Misalignment rule:
  - H/HU with addr[0] = 1 is misaligned.
  - W with addr[1:0] != 0 is misaligned.
  - Undefined funct3 values (011, 110, 111) are treated as misaligned.
- Out-of-range rule: addr[31:2] >= DEPTH_WORDS.
- Check priority: misaligned over out of range.
- On a faulting accept: no memory request is issued; fault pulses at T+1 with cause and address; no resp_valid; state stays IDLE.
- IDLE -> WAIT (good accept at T):
  - From T+1, mem_req = 1 and mem_we, mem_addr, mem_be, mem_wdata are registered and held stable until ack.
  - Byte enables: B -> 0001 << addr[1:0]; H -> 0011 << addr[1:0]; W -> 1111.
  - Store data: byte replicated to all four lanes for B, halfword replicated to both halves for H.
  - Loads drive mem_be for the accessed lanes; memory ignores it on reads.
- WAIT:
  - The counter increments each cycle.
  - mem_ack may arrive in the first WAIT cycle (combinational memory); the minimum latency is accept T -> resp_valid T+2.
  - On mem_ack: mem_req drops next cycle and state -> RESP. For loads, the selected lane is captured and extended: B/H sign-extend, BU/HU zero-extend, W passes through.
  - If the counter reaches TIMEOUT without ack: mem_req drops, fault pulses with cause 11, state -> IDLE, no resp.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. Stores also pulse resp_valid, with rdata = 0 and rd = 0.
- mem_ack outside WAIT is ignored.
- An asynchronous reset mid-transaction aborts immediately: mem_req = 0 and no resp or fault is produced.
- A new request is never accepted in the cycle resp_valid is high; back-to-back throughput is one operation per 3 cycles minimum.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state encoding IDLE/WAIT/RESP;
  - fault cause constants.
- One sub-module, lsu_align: purely combinational.
  - Store side: funct3 + addr[1:0] + wdata -> be + lane data.
  - Load side: funct3 + addr[1:0] + rdata -> extended result.
  - Verified standalone with an exhaustive sweep.

Test Plan:
- SW addr 0x1C, data 0xDEADBEEF, mem_ack in first WAIT cycle -> mem_addr 7, mem_be 1111, mem_wdata 0xDEADBEEF; resp_valid at T+2 with rd 0; stall high for T+1..T+2.
- LB addr 0x1D, mem_rdata 0x12348056 -> mem_be 0010, resp_rdata 0x00000080? No: lane 1 = 0x80 gives 0xFFFFFF80. The same access as LBU gives 0x00000080.
- SH addr 0x06, wdata 0x0000ABCD -> mem_addr 1, mem_be 1100, mem_wdata 0xABCDABCD. LHU addr 0x06 with rdata 0xABCD0000 gives 0x0000ABCD.
- LW addr 0x02 -> fault cause 01, fault_addr 0x2 at T+1, mem_req never asserted. LW addr 0x1000 (word 1024) gives fault cause 10.
- LW with mem_ack held low -> mem_req high for 15 cycles, then fault cause 11, state IDLE, req_ready 1. A late mem_ack afterwards is ignored.
- Assert rst_n low during WAIT -> mem_req 0 immediately, no resp_valid or fault. The next request after reset completes normally.
